// File: rtl/qos_pkg.sv
// Shared constants and FSM state type for the QoS class arbiter.
package qos_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int ID_W        = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/qos_rr_next.sv
// Cyclic find-next-set over the class eligibility mask, starting just after i_ptr
// and wrapping around to i_ptr itself as the last candidate.
module qos_rr_next
  import qos_pkg::*;
(
  input  logic [NUM_CLASSES-1:0] i_mask,
  input  logic [ID_W-1:0]        i_ptr,
  output logic [ID_W-1:0]        o_idx,
  output logic                   o_found
);

  logic [ID_W-1:0] w_cand;

  // Walk from the farthest offset down so the nearest set bit wins.
  always_comb begin
    o_idx   = i_ptr;
    o_found = 1'b0;
    w_cand  = i_ptr;
    for (int i = NUM_CLASSES; i >= 1; i--) begin
      w_cand = i_ptr + ID_W'(i);
      if (i_mask[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_arbiter.sv
// Four-class weighted round-robin arbiter draining class FIFOs into one output FIFO.
// Optional build macro QOS_STRICT_PRIO_EN: class 0 is served ahead of WRR whenever eligible.
module qos_arbiter
  import qos_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CFEMPTY0,
  input  logic                CFEMPTY1,
  input  logic                CFEMPTY2,
  input  logic                CFEMPTY3,
  input  logic [DATA_W-1:0]   CFDATA0,
  input  logic [DATA_W-1:0]   CFDATA1,
  input  logic [DATA_W-1:0]   CFDATA2,
  input  logic [DATA_W-1:0]   CFDATA3,
  input  logic [WEIGHT_W-1:0] WEIGHT0,
  input  logic [WEIGHT_W-1:0] WEIGHT1,
  input  logic [WEIGHT_W-1:0] WEIGHT2,
  input  logic [WEIGHT_W-1:0] WEIGHT3,
  input  logic                OALMOSTFULL,
  output logic                CFPOP0,
  output logic                CFPOP1,
  output logic                CFPOP2,
  output logic                CFPOP3,
  output logic                PUSHDATOSALIDA,
  output logic [DATA_W-1:0]   DATOSALIDA,
  output logic [ID_W-1:0]     IDSALIDA
);

  logic [NUM_CLASSES-1:0] w_empty;
  logic [NUM_CLASSES-1:0] w_elig;
  logic [WEIGHT_W-1:0]    w_weight [NUM_CLASSES];
  logic [DATA_W-1:0]      w_cfdata [NUM_CLASSES];

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        w_ptr_nxt;
  logic [WEIGHT_W-1:0]    r_cred;
  logic [WEIGHT_W-1:0]    w_cred_nxt;

  logic                   w_go;
  logic                   w_strict;
  logic                   w_pop;
  logic [ID_W-1:0]        w_gnt_id;
  logic [ID_W-1:0]        w_rr_idx;
  logic                   w_rr_found;

  logic                   r_cap_vld;
  logic [ID_W-1:0]        r_cap_id;
  logic                   r_push;
  logic [DATA_W-1:0]      r_dat;
  logic [ID_W-1:0]        r_id;

  assign w_empty     = {CFEMPTY3, CFEMPTY2, CFEMPTY1, CFEMPTY0};
  assign w_weight[0] = WEIGHT0;
  assign w_weight[1] = WEIGHT1;
  assign w_weight[2] = WEIGHT2;
  assign w_weight[3] = WEIGHT3;
  assign w_cfdata[0] = CFDATA0;
  assign w_cfdata[1] = CFDATA1;
  assign w_cfdata[2] = CFDATA2;
  assign w_cfdata[3] = CFDATA3;

  always_comb begin
    w_elig = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      w_elig[k] = ~w_empty[k] & (w_weight[k] != '0);
    end
  end

  qos_rr_next u_rr_next (
    .i_mask  (w_elig),
    .i_ptr   (r_ptr),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  always_comb begin
    w_strict = 1'b0;
`ifdef QOS_STRICT_PRIO_EN
    w_strict = w_elig[0];
`endif
  end

  // Pop decision is purely combinational so the FIFO sees the strobe in the grant cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_gnt_id    = r_ptr;
    w_ptr_nxt   = r_ptr;
    w_cred_nxt  = r_cred;
    w_go        = (|w_elig) & ~OALMOSTFULL & ~RESET;

    case (r_state)
      IDLE:    if (w_go)  w_state_nxt = SERVE;
      SERVE:   if (!w_go) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (w_go) begin
      if (w_strict) begin
        w_pop    = 1'b1;
        w_gnt_id = '0;
      end else if (w_elig[r_ptr] && (r_cred < w_weight[r_ptr])) begin
        w_pop      = 1'b1;
        w_gnt_id   = r_ptr;
        w_cred_nxt = r_cred + WEIGHT_W'(1);
      end else if (w_rr_found) begin
        w_pop      = 1'b1;
        w_gnt_id   = w_rr_idx;
        w_ptr_nxt  = w_rr_idx;
        w_cred_nxt = WEIGHT_W'(1);
      end
    end
  end

  assign CFPOP0 = w_pop & (w_gnt_id == 2'd0);
  assign CFPOP1 = w_pop & (w_gnt_id == 2'd1);
  assign CFPOP2 = w_pop & (w_gnt_id == 2'd2);
  assign CFPOP3 = w_pop & (w_gnt_id == 2'd3);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cred  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cred  <= w_cred_nxt;
    end
  end

  // Two-stage output pipe: remember the popped class, then capture its FIFO data next cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cap_vld <= 1'b0;
      r_cap_id  <= '0;
      r_push    <= 1'b0;
      r_dat     <= '0;
      r_id      <= '0;
    end else begin
      r_cap_vld <= w_pop;
      if (w_pop) r_cap_id <= w_gnt_id;
      r_push <= r_cap_vld;
      if (r_cap_vld) begin
        r_dat <= w_cfdata[r_cap_id];
        r_id  <= r_cap_id;
      end
    end
  end

  // Masking with RESET drops in-flight words from the very first reset cycle.
  assign PUSHDATOSALIDA = r_push & ~RESET;
  assign DATOSALIDA     = RESET ? '0 : r_dat;
  assign IDSALIDA       = RESET ? '0 : r_id;

endmodule

// File: tb/tb_qos_arbiter.sv
// Self-checking bench for qos_arbiter: emulated class FIFOs plus a WRR reference model.
module tb_qos_arbiter;

  localparam int DW = 8;
  localparam int WW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CFEMPTY0, CFEMPTY1, CFEMPTY2, CFEMPTY3;
  logic [DW-1:0] CFDATA0, CFDATA1, CFDATA2, CFDATA3;
  logic [WW-1:0] WEIGHT0, WEIGHT1, WEIGHT2, WEIGHT3;
  logic          OALMOSTFULL;
  logic          CFPOP0, CFPOP1, CFPOP2, CFPOP3;
  logic          PUSHDATOSALIDA;
  logic [DW-1:0] DATOSALIDA;
  logic [1:0]    IDSALIDA;

  always #5 CLK = ~CLK;

  qos_arbiter #(.DATA_W(DW), .WEIGHT_W(WW)) dut (
    .CLK(CLK), .RESET(RESET),
    .CFEMPTY0(CFEMPTY0), .CFEMPTY1(CFEMPTY1), .CFEMPTY2(CFEMPTY2), .CFEMPTY3(CFEMPTY3),
    .CFDATA0(CFDATA0), .CFDATA1(CFDATA1), .CFDATA2(CFDATA2), .CFDATA3(CFDATA3),
    .WEIGHT0(WEIGHT0), .WEIGHT1(WEIGHT1), .WEIGHT2(WEIGHT2), .WEIGHT3(WEIGHT3),
    .OALMOSTFULL(OALMOSTFULL),
    .CFPOP0(CFPOP0), .CFPOP1(CFPOP1), .CFPOP2(CFPOP2), .CFPOP3(CFPOP3),
    .PUSHDATOSALIDA(PUSHDATOSALIDA), .DATOSALIDA(DATOSALIDA), .IDSALIDA(IDSALIDA)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q [4][$];
  logic [WW-1:0] wt [4];
  logic [DW-1:0] cfd [4];

  // reference model state: arbitration pointer/credit and the two-cycle output pipe
  int            m_ptr, m_cred;
  bit            m_s1_vld, m_vld;
  int            m_s1_id, m_id;
  logic [DW-1:0] m_s1_dat, m_dat;

  int pop_log[$];
  int push_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    CFEMPTY0 = (q[0].size() == 0);
    CFEMPTY1 = (q[1].size() == 0);
    CFEMPTY2 = (q[2].size() == 0);
    CFEMPTY3 = (q[3].size() == 0);
    WEIGHT0 = wt[0]; WEIGHT1 = wt[1]; WEIGHT2 = wt[2]; WEIGHT3 = wt[3];
    CFDATA0 = cfd[0]; CFDATA1 = cfd[1]; CFDATA2 = cfd[2]; CFDATA3 = cfd[3];
  endtask

  task automatic fill(input int k, input int n);
    repeat (n) q[k].push_back(DW'($urandom));
    drive();
  endtask

  // One clock cycle: predict, sample at negedge, then advance FIFOs and model after posedge.
  task automatic cycle();
    bit            el [4];
    int            g, np, nc;
    logic [3:0]    exp_pop, obs_pop;
    logic [DW-1:0] gw;
    bit            rst_now;
    for (int k = 0; k < 4; k++) el[k] = (q[k].size() != 0) && (wt[k] != 0);
    g  = -1;
    np = m_ptr;
    nc = m_cred;
    if (!RESET && !OALMOSTFULL && (el[0] || el[1] || el[2] || el[3])) begin
`ifdef QOS_STRICT_PRIO_EN
      if (el[0]) g = 0;
`endif
      if (g < 0) begin
        if (el[m_ptr] && m_cred < int'(wt[m_ptr])) begin
          g  = m_ptr;
          nc = m_cred + 1;
        end else begin
          for (int i = 1; i <= 4; i++) begin
            if (el[(m_ptr + i) % 4]) begin
              g  = (m_ptr + i) % 4;
              np = g;
              nc = 1;
              break;
            end
          end
        end
      end
    end
    exp_pop = (g >= 0) ? 4'(1 << g) : 4'b0;
    gw      = (g >= 0) ? q[g][0] : '0;

    @(negedge CLK);
    obs_pop = {CFPOP3, CFPOP2, CFPOP1, CFPOP0};
    chk("cfpop", 32'(obs_pop), 32'(exp_pop));
    chk("push", 32'(PUSHDATOSALIDA), 32'(!RESET && m_vld));
    chk("data", 32'(DATOSALIDA), RESET ? 32'd0 : 32'(m_dat));
    chk("id", 32'(IDSALIDA), RESET ? 32'd0 : 32'(m_id));
    for (int k = 0; k < 4; k++) if (obs_pop[k]) pop_log.push_back(k);
    if (PUSHDATOSALIDA) push_log.push_back(int'(IDSALIDA));
    rst_now = RESET;

    @(posedge CLK);
    #1;
    for (int k = 0; k < 4; k++)
      if (obs_pop[k] && q[k].size() > 0) cfd[k] = q[k].pop_front();
    if (rst_now) begin
      m_ptr = 0; m_cred = 0;
      m_s1_vld = 0; m_s1_id = 0; m_s1_dat = '0;
      m_vld = 0; m_id = 0; m_dat = '0;
    end else begin
      m_ptr  = np;
      m_cred = nc;
      m_vld  = m_s1_vld;
      if (m_s1_vld) begin
        m_dat = m_s1_dat;
        m_id  = m_s1_id;
      end
      m_s1_vld = (g >= 0);
      if (g >= 0) begin
        m_s1_id  = g;
        m_s1_dat = gw;
      end
    end
    drive();
  endtask

  task automatic reset_and_clear();
    for (int k = 0; k < 4; k++) q[k].delete();
    RESET = 1'b1;
    drive();
    cycle();
    cycle();
    RESET = 1'b0;
    drive();
    pop_log.delete();
    push_log.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp034 [10];
    int exp035 [6];
    int n1;
    exp034 = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
    exp035 = '{0, 2, 3, 0, 2, 3};
    m_ptr = 0; m_cred = 0; m_s1_vld = 0; m_s1_id = 0; m_s1_dat = '0;
    m_vld = 0; m_id = 0; m_dat = '0;
    for (int k = 0; k < 4; k++) begin wt[k] = 4'd1; cfd[k] = '0; end
    RESET = 1'b1;
    OALMOSTFULL = 1'b0;
    drive();
    @(posedge CLK);
    #1;

    // reset state, then a single class holding three words
    reset_and_clear();
    fill(2, 3);
    repeat (6) cycle();
    chk("c2_pops", pop_log.size(), 3);
    chk("c2_pushes", push_log.size(), 3);
    for (int i = 0; i < push_log.size(); i++) chk("c2_push_id", push_log[i], 2);

`ifndef QOS_STRICT_PRIO_EN
    // weights 2,1,1,1 with every class backlogged
    reset_and_clear();
    wt[0] = 4'd2;
    for (int k = 0; k < 4; k++) fill(k, 20);
    repeat (10) cycle();
    chk("wrr_n", pop_log.size(), 10);
    for (int i = 0; i < 10 && i < pop_log.size(); i++) chk("wrr_order", pop_log[i], exp034[i]);

    // class 1 disabled by zero weight
    reset_and_clear();
    wt[0] = 4'd1; wt[1] = 4'd0;
    for (int k = 0; k < 4; k++) fill(k, 20);
    repeat (6) cycle();
    chk("w0_n", pop_log.size(), 6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++) chk("w0_order", pop_log[i], exp035[i]);
    n1 = 0;
    foreach (pop_log[i]) if (pop_log[i] == 1) n1++;
    chk("w0_no_c1", n1, 0);
`else
    // class 0 strictly ahead of class 1
    reset_and_clear();
    for (int k = 0; k < 4; k++) wt[k] = 4'd1;
    fill(0, 3);
    fill(1, 3);
    repeat (8) cycle();
    chk("strict_n", pop_log.size(), 6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++) chk("strict_order", pop_log[i], (i < 3) ? 0 : 1);
`endif

    // almost-full backpressure during streaming
    reset_and_clear();
    for (int k = 0; k < 4; k++) wt[k] = 4'd1;
    for (int k = 0; k < 4; k++) fill(k, 20);
    repeat (5) cycle();
    OALMOSTFULL = 1'b1;
    drive();
    pop_log.delete();
    push_log.delete();
    repeat (4) cycle();
    chk("af_no_pop", pop_log.size(), 0);
    chk("af_inflight", push_log.size(), 2);
    OALMOSTFULL = 1'b0;
    drive();
    pop_log.delete();
    cycle();
    chk("af_resume", pop_log.size(), 1);

    // reset one cycle after a pop drops that word and restarts at class 0
    reset_and_clear();
    fill(3, 1);
    cycle();
    chk("rst_pop_seen", pop_log.size(), 1);
    RESET = 1'b1;
    drive();
    cycle();
    RESET = 1'b0;
    drive();
    push_log.delete();
    repeat (4) cycle();
    chk("rst_drop", push_log.size(), 0);
    for (int k = 0; k < 4; k++) fill(k, 4);
    pop_log.delete();
    cycle();
    chk("rst_restart_n", pop_log.size(), 1);
    chk("rst_restart_cls", (pop_log.size() > 0) ? pop_log[0] : -1, 0);

    // randomized traffic, weights, backpressure and occasional reset
    reset_and_clear();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 2) == 0 && q[k].size() < 6) q[k].push_back(DW'($urandom));
      OALMOSTFULL = ($urandom_range(0, 4) == 0);
      RESET = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) wt[$urandom_range(0, 3)] = WW'($urandom_range(0, 3));
      drive();
      cycle();
    end
    RESET = 1'b0;
    OALMOSTFULL = 1'b0;
    drive();
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qos_arbiter.md
QOS_ARBITER -- requirements
Module: qos_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of each class-FIFO data word and of the output word.
REQ-002 Parameter WEIGHT_W, default 4: width of each per-class weight input and of the credit counter.
REQ-003 Port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1: synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 Ports CFEMPTY0..CFEMPTY3, input, 1 each: empty flag of class FIFO 0..3.
REQ-006 Ports CFDATA0..CFDATA3, input, DATA_W each: read data of class FIFO 0..3, valid the cycle after its pop.
REQ-007 Ports WEIGHT0..WEIGHT3, input, WEIGHT_W each: WRR weight per class; 0 disables the class.
REQ-008 Port OALMOSTFULL, input, 1: output FIFO has at most 2 free slots.
REQ-009 Ports CFPOP0..CFPOP3, output, 1 each: pop strobe to class FIFO 0..3; at most one high per cycle.
REQ-010 Port PUSHDATOSALIDA, output, 1: push strobe to the output FIFO.
REQ-011 Port DATOSALIDA, output, DATA_W: word pushed to the output FIFO.
REQ-012 Port IDSALIDA, output, 2: class ID of the word on DATOSALIDA.

Function
REQ-013 A class is eligible in a cycle if CFEMPTYk=0 and WEIGHTk!=0.
REQ-014 CFPOPk is combinational from the registered state and the current-cycle inputs; all CFPOPk are 0 whenever OALMOSTFULL=1 or RESET=1.
REQ-015 The FSM has two states: IDLE (no pop) and SERVE (one pop per cycle).
REQ-016 IDLE->SERVE when any class is eligible and OALMOSTFULL=0; SERVE->IDLE when no class is eligible or OALMOSTFULL=1.
REQ-017 A pop is issued in the same cycle that the FSM leaves IDLE and in every cycle spent in SERVE.
REQ-018 Registered state: class pointer PTR (2 bits) and credit counter CRED (WEIGHT_W bits).
REQ-019 Grant rule: if class PTR is eligible and CRED<WEIGHT[PTR], pop PTR and increment CRED.
REQ-020 Otherwise, pop the first eligible class in cyclic order PTR+1, PTR+2, PTR+3, PTR (mod 4); load PTR with that class and set CRED=1.
REQ-021 Weight changes take effect from the next grant decision; a class whose CRED already equals or exceeds its new weight is advanced past.
REQ-022 Pipeline: a pop in cycle N captures class k; in N+1 CFDATAk is registered into DATOSALIDA and k into IDSALIDA; PUSHDATOSALIDA=1 in N+2. Latency from pop to push is exactly 2 cycles; throughput is 1 word/cycle.
REQ-023 Words already in flight when OALMOSTFULL rises are still pushed; no word is dropped or duplicated.
REQ-024 If all classes are empty, no pop occurs and PTR/CRED hold their values.
REQ-025 DATOSALIDA and IDSALIDA hold their last values when PUSHDATOSALIDA=0.

Reset
REQ-026 While RESET=1: state=IDLE, PTR=0, CRED=0, all CFPOP=0, PUSHDATOSALIDA=0, DATOSALIDA=0, IDSALIDA=0.
REQ-027 Reset asserted mid-transfer discards in-flight words: PUSHDATOSALIDA=0 from the first cycle of reset onward.
REQ-028 The first pop is possible in the first cycle after RESET deasserts.

Configuration
REQ-029 Macro QOS_STRICT_PRIO_EN: when defined, eligible class 0 is always granted ahead of WRR; such grants change neither PTR nor CRED, and classes 1-3 are served by WRR only while class 0 is not eligible.
REQ-030 When QOS_STRICT_PRIO_EN is undefined, class 0 is arbitrated under pure WRR like classes 1-3.

Structure
REQ-031 Package qos_pkg holds NUM_CLASSES=4, the class-ID width (2), and the FSM state enum (IDLE, SERVE).
REQ-032 Sub-module qos_rr_next: combinational cyclic find-next-set over a 4-bit eligibility mask starting after PTR; returns the class index and a found flag.

Verification
REQ-033 Only class 2 holds 3 words, all weights 1 -> CFPOP2 high for 3 consecutive cycles; 3 pushes, each 2 cycles after its pop, with IDSALIDA=2.
REQ-034 All classes continuously non-empty, weights 2,1,1,1 -> pop order 0,0,1,2,3,0,0,1,...
REQ-035 WEIGHT1=0, others 1, all classes non-empty -> pop order 0,2,3,0,2,3; CFPOP1 never asserts.
REQ-036 OALMOSTFULL=1 for 4 cycles during streaming -> no CFPOP in those cycles; the 2 in-flight words are pushed; streaming resumes the cycle OALMOSTFULL falls.
REQ-037 RESET pulsed 1 cycle after a pop -> that word is never pushed; PTR=0, CRED=0; arbitration restarts from class 0.
REQ-038 With QOS_STRICT_PRIO_EN defined, classes 0 and 1 non-empty, weights 1 -> only CFPOP0 until class 0 is empty, then CFPOP1.
